// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage sitting directly upstream of decode.
// Owns the PC, issues in-order word requests to instruction memory, buffers
// returned words with their PCs and presents them to decode on a
// valid/ready handshake. A redirect (pc_load) flushes the buffer and marks
// every request still in flight to be discarded when it returns.
//
// Optional build macro: FETCH_BYPASS_EN
//   defined   - a response arriving while the buffer is empty (and nothing is
//               being dropped or redirected) is presented to decode in the same
//               cycle; it is written to the buffer only if decode stalls.
//   undefined - responses always pass through the buffer (one cycle latency).
module core_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [31:0] pc_new,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_ir,
  input  logic        d_ready,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data
);

  // Buffer index width; the pointers carry one extra wrap bit so that
  // occupancy is a plain subtraction with no full/empty ambiguity.
  localparam int BW = $clog2(FIFO_DEPTH);
  // In-flight queue index width (at least one bit so MAX_OUTST=1 still works).
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int QD = 1 << QW;
  // Width wide enough to add the two occupancies without overflow.
  localparam int SW = ((BW > QW) ? BW : QW) + 2;

  localparam logic [QW:0]   Q_ONE     = (QW+1)'(1);
  localparam logic [BW:0]   B_ONE     = (BW+1)'(1);
  localparam logic [QW:0]   OUTST_MAX = (QW+1)'(MAX_OUTST);
  localparam logic [SW-1:0] CREDIT    = SW'(FIFO_DEPTH);

  // Architectural state.
  logic [31:0] pc;
  logic        run;        // low for the first cycle after reset
  logic [QW:0] q_wr;
  logic [QW:0] q_rd;
  logic [QW:0] drop_cnt;
  logic [BW:0] b_wr;
  logic [BW:0] b_rd;

  logic [31:0] q_addr [QD];
  logic [31:0] buf_pc [FIFO_DEPTH];
  logic [31:0] buf_ir [FIFO_DEPTH];

  // Derived occupancy and handshake terms.
  logic [QW:0]   outst;
  logic [BW:0]   count;
  logic [SW-1:0] credit_sum;
  logic          buf_empty;
  logic          req_fire;
  logic          rsp_keep;
  logic          buf_push;
  logic          buf_pop;

  assign outst      = q_wr - q_rd;
  assign count      = b_wr - b_rd;
  assign credit_sum = SW'(outst) + SW'(count);
  assign buf_empty  = (count == '0);

  // Credit rule: a request may only go out if a buffer slot is reserved for
  // its response, so a response can never arrive to a full buffer.
  assign imem_req_valid = run && !pc_load && (credit_sum < CREDIT) && (outst < OUTST_MAX);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only if it is not a wrong-path leftover and no
  // redirect is happening in the same cycle.
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !pc_load;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass   = buf_empty && rsp_keep;
  assign d_valid  = (!buf_empty && !pc_load) || bypass;
  assign d_pc     = bypass ? q_addr[q_rd[QW-1:0]] : buf_pc[b_rd[BW-1:0]];
  assign d_ir     = bypass ? imem_rsp_data        : buf_ir[b_rd[BW-1:0]];
  assign buf_push = rsp_keep && !(bypass && d_ready);
  assign buf_pop  = d_valid && d_ready && !bypass;
`else
  assign d_valid  = !buf_empty && !pc_load;
  assign d_pc     = buf_pc[b_rd[BW-1:0]];
  assign d_ir     = buf_ir[b_rd[BW-1:0]];
  assign buf_push = rsp_keep;
  assign buf_pop  = d_valid && d_ready;
`endif

  // PC, queue/buffer pointers and the wrong-path drop counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      run      <= 1'b0;
      q_wr     <= '0;
      q_rd     <= '0;
      drop_cnt <= '0;
      b_wr     <= '0;
      b_rd     <= '0;
    end else begin
      run <= 1'b1;

      if (pc_load)       pc <= pc_new & 32'hFFFF_FFFC;
      else if (req_fire) pc <= pc + 32'd4;

      if (req_fire)       q_wr <= q_wr + Q_ONE;
      if (imem_rsp_valid) q_rd <= q_rd + Q_ONE;

      // Every request still outstanding after this cycle is wrong-path.
      if (pc_load)
        drop_cnt <= outst - {{QW{1'b0}}, imem_rsp_valid};
      else if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - Q_ONE;

      if (buf_push) b_wr <= b_wr + B_ONE;

      if (pc_load)      b_rd <= b_wr;
      else if (buf_pop) b_rd <= b_rd + B_ONE;
    end
  end

  // In-flight address queue storage: records the PC of each accepted request.
  // NOTE: this storage has no reset; an entry is always written before it is
  // read. The small decode buffer below is reset so d_pc/d_ir read 0.
  always_ff @(posedge clk) begin
    if (req_fire) q_addr[q_wr[QW-1:0]] <= pc;
  end

  // Instruction buffer storage: {pc, word} pairs awaiting decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc[i] <= '0;
        buf_ir[i] <= '0;
      end
    end else if (buf_push) begin
      buf_pc[b_wr[BW-1:0]] <= q_addr[q_rd[QW-1:0]];
      buf_ir[b_wr[BW-1:0]] <= imem_rsp_data;
    end
  end

endmodule
